ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//   Request-side sequencer for the shared 8-bit memory bus, directly upstream of the RAM.
//   Accepts one read or write request per valid/ready handshake.
//   Expands each request into the RAM's multi-cycle bus protocol: address phase, then data phase.
//   Returns read data, or write completion, on a one-cycle response pulse.
//   Sole bus driver other than the RAM itself.
// PARAMETERS
//   BITW  8  address and data width (shared bus, so both are equal)
// PORTS
//   clock      in     1     system clock; all logic on posedge
//   reset      in     1     synchronous, active-high reset
//   req_valid  in     1     request present
//   req_ready  out    1     block can accept a request (high only in IDLE)
//   req_we     in     1     1 = write, 0 = read
//   req_addr   in     BITW  target address
//   req_wdata  in     BITW  write data (ignored for reads)
//   rsp_valid  out    1     one-cycle pulse: request completed
//   rsp_we     out    1     kind of completed request (valid with rsp_valid)
//   rsp_rdata  out    BITW  read data (valid with rsp_valid when rsp_we=0)
//   mem_enable out    1     RAM enable
//   mem_rw     out    1     RAM direction: 0 = read, 1 = write
//   bus        inout  BITW  shared tri-state bus, driven through tri_buf
// BEHAVIOUR
// Reset
//   - Reset at any cycle, including mid-transaction, forces state IDLE.
//   - Reset values: mem_enable=0, mem_rw=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, bus released (high-Z).
//   - req_ready=1 in the first cycle after reset.
//   - The RAM shares the same reset (inverted at top level), so no partial transaction survives.
// Registered outputs
//   - All outputs and the bus drive enable are registered; no combinational path from req_* to mem_*/bus.
// Handshake
//   - Accept on a posedge where req_valid && req_ready.
//   - req_we, req_addr and req_wdata are latched at accept; later changes are ignored.
// States
//   IDLE  : req_ready=1, mem_enable=0, bus released. On accept -> ADDR.
//   ADDR  : mem_enable=1, mem_rw=req_we, bus=addr. Next state: WDATA if write, else RWAIT.
//   RWAIT : mem_enable=1, mem_rw=0, bus released. The RAM loads data at the closing edge. -> RCAP.
//   RCAP  : mem_enable=0, bus released, RAM drives the bus.
//           At the closing edge: capture bus into rsp_rdata, rsp_valid=1, rsp_we=0. -> IDLE.
//   WDATA : mem_enable=1, mem_rw=1, bus=wdata. The RAM writes at the closing edge.
//           At that edge: rsp_valid=1, rsp_we=1. -> IDLE.
// Latency, counted from the accept edge E0
//   - Read: rsp_valid is high in the cycle after E3 (3 cycles).
//   - Write: rsp_valid is high in the cycle after E2 (2 cycles).
//   - Next accept is possible at the edge ending the rsp_valid cycle.
//   - Throughput: 1 read per 4 cycles, 1 write per 3 cycles.
// Bus rules
//   - mem_enable must be 0 during RCAP. Otherwise the RAM would latch the read data as a new address.
//   - The master never drives the bus in RWAIT, RCAP or IDLE, so there is never a cycle with two drivers.
//   - Master drive starts only in ADDR, after the RAM has released the bus at E3.
// Other rules
//   - rsp_rdata holds its last value until the next read completes; writes do not alter it.
//   - Address 0xFF and data 0xFF/0x00 need no special handling; addresses do not wrap or increment.
//   - req_valid held high continuously produces back-to-back transactions at the rates above.
// TESTING
//   1. Reset: assert reset 2 cycles mid-read (in RWAIT).
//      -> next cycle: IDLE, req_ready=1, mem_enable=0, bus=Z, rsp_valid=0.
//   2. Write then read: write addr 0x10 data 0xA5, then read 0x10.
//      -> write rsp after 2 cycles; read rsp_valid 3 cycles after accept with rsp_rdata=0xA5.
//   3. Fresh read: after reset, read 0x3C.
//      -> rsp_rdata=0x00, rsp_we=0, single-cycle rsp_valid.
//   4. Back-to-back stream: req_valid held high for writes 0xFF<-0x5A, 0x00<-0xC3, then reads 0xFF, 0x00.
//      -> accepts spaced 3,3,4 cycles apart; read data 0x5A, 0xC3.
//   5. Input stability: change req_addr/req_wdata during ADDR/WDATA.
//      -> latched values are used; no effect on memory.
//   6. Bus contention check: assert no cycle where the master drive enable and the RAM drive are both active.
//      Assert mem_enable=0 in every RCAP cycle.

Source files
------------

// File: rtl/ram_bus_master.sv
// Request-side sequencer for the shared 8-bit RAM bus: expands each accepted
// read/write request into an address phase and a data phase on a tri-state bus.

module tri_buf #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] d,
    output wire  [W-1:0] y
);
    assign y = en ? d : {W{1'bz}};
endmodule

module ram_bus_master #(
    parameter int BITW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [BITW-1:0] req_addr,
    input  logic [BITW-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_we,
    output logic [BITW-1:0] rsp_rdata,
    output logic            mem_enable,
    output logic            mem_rw,
    inout  wire  [BITW-1:0] bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RWAIT,
        RCAP,
        WDATA
    } state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              we_q;
    logic [BITW-1:0]   wdata_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [BITW-1:0]   rsp_rdata_q;
    logic              mem_enable_q;
    logic              mem_rw_q;
    logic              bus_oe_q;
    logic [BITW-1:0]   bus_out_q;

    // Every output is set on the edge that enters the state it belongs to,
    // so nothing on req_* reaches mem_* or the bus without a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            bus_oe_q     <= 1'b0;
            bus_out_q    <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples the
            // pre-edge values; a blocking = here would chain updates in order.
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q         <= req_we;
                        wdata_q      <= req_wdata;
                        bus_out_q    <= req_addr;
                        bus_oe_q     <= 1'b1;
                        mem_enable_q <= 1'b1;
                        mem_rw_q     <= req_we;
                        req_ready_q  <= 1'b0;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    if (we_q) begin
                        bus_out_q <= wdata_q;
                        mem_rw_q  <= 1'b1;
                        state_q   <= WDATA;
                    end else begin
                        bus_oe_q <= 1'b0;
                        mem_rw_q <= 1'b0;
                        state_q  <= RWAIT;
                    end
                end
                RWAIT: begin
                    // Dropping enable here keeps the RAM from taking its own
                    // read data as a fresh address during RCAP.
                    mem_enable_q <= 1'b0;
                    state_q      <= RCAP;
                end
                RCAP: begin
                    rsp_rdata_q <= bus;
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                WDATA: begin
                    bus_oe_q     <= 1'b0;
                    mem_enable_q <= 1'b0;
                    mem_rw_q     <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    rsp_we_q     <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    bus_oe_q     <= 1'b0;
                    mem_enable_q <= 1'b0;
                    mem_rw_q     <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    tri_buf #(.W(BITW)) u_bus_buf (
        .en (bus_oe_q),
        .d  (bus_out_q),
        .y  (bus)
    );

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_we     = rsp_we_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign mem_enable = mem_enable_q;
    assign mem_rw     = mem_rw_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural RAM on the shared bus.

module tb_ram_bus_master;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_we;
    logic [7:0] rsp_rdata;
    logic       mem_enable;
    logic       mem_rw;
    wire  [7:0] bus;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_bus_master #(.BITW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .bus        (bus)
    );

    // RAM model: first enabled cycle takes the address, second does the data
    // phase; read data is driven for the cycle after that.
    logic [7:0] ram_mem [256];
    logic       ram_phase;
    logic       ram_drive;
    logic [7:0] ram_addr;
    logic [7:0] ram_dout;

    assign bus = ram_drive ? ram_dout : 8'bz;

    always @(posedge clock) begin
        if (reset) begin
            ram_phase <= 1'b0;
            ram_drive <= 1'b0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (mem_enable) begin
            if (!ram_phase) begin
                ram_addr  <= bus;
                ram_phase <= 1'b1;
            end else begin
                ram_phase <= 1'b0;
                if (mem_rw) ram_mem[ram_addr] <= bus;
                else begin
                    ram_dout  <= ram_mem[ram_addr];
                    ram_drive <= 1'b1;
                end
            end
        end else begin
            ram_drive <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bus ownership: master may drive only while the RAM is enabled and idle
    // on the bus; the RAM drive cycle (RCAP) must have enable low.
    always @(negedge clock) begin
        if (!reset) begin
            if (ram_drive) begin
                check("rcap_enable", {31'd0, mem_enable}, 32'd0);
                check("contention", {31'd0, dut.bus_oe_q}, 32'd0);
            end
            if (dut.bus_oe_q) check("drive_needs_enable", {31'd0, mem_enable}, 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // One isolated request; optionally scrambles the inputs after accept.
    task automatic transact(input string tag, input logic we, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] exp_rdata,
                            input logic scramble);
        int lat = 0;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_ready(tag);
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (scramble) begin
            req_we = ~we; req_addr = ~a; req_wdata = ~d;
        end
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1; lat++;
            if (scramble) begin req_addr = req_addr + 8'd7; req_wdata = req_wdata + 8'd3; end
        end
        check({tag, "_latency"}, lat, we ? 32'd2 : 32'd3);
        check({tag, "_rsp_we"}, {31'd0, rsp_we}, {31'd0, we});
        check({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rdata});
        @(posedge clock); #1;
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin @(posedge clock); #1; end
        reset = 1'b0;
    endtask

    task automatic stream();
        logic       s_we [4]    = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] s_addr [4]  = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        logic [7:0] s_wdata [4] = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        int acc [4];
        int lat = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_we = s_we[i]; req_addr = s_addr[i]; req_wdata = s_wdata[i];
            wait_ready("stream");
            if (i > 0) begin
                check("stream_rsp", {31'd0, rsp_valid}, 32'd1);
                check("stream_rsp_we", {31'd0, rsp_we}, {31'd0, s_we[i-1]});
            end
            if (i == 3) check("stream_rd_ff", {24'd0, rsp_rdata}, 32'h5A);
            @(posedge clock); #1;
            acc[i] = cyc;
        end
        req_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        check("stream_last_rsp", {31'd0, rsp_valid}, 32'd1);
        check("stream_rd_00", {24'd0, rsp_rdata}, 32'hC3);
        check("stream_gap_ww", acc[1] - acc[0], 32'd3);
        check("stream_gap_wr", acc[2] - acc[1], 32'd3);
        check("stream_gap_rr", acc[3] - acc[2], 32'd4);
        @(posedge clock); #1;
    endtask

    initial begin
        do_reset(3);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_enable", {31'd0, mem_enable}, 32'd0);
        check("rst_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_we", {31'd0, rsp_we}, 32'd0);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_bus_oe", {31'd0, dut.bus_oe_q}, 32'd0);

        transact("fresh_rd", 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0);
        transact("wr_10", 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        transact("rd_10", 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        transact("wr_keep", 1'b1, 8'h20, 8'h11, 8'hA5, 1'b0);

        transact("stab_wr", 1'b1, 8'h44, 8'h99, 8'hA5, 1'b1);
        transact("stab_rd", 1'b0, 8'h44, 8'h00, 8'h99, 1'b1);
        transact("stab_other", 1'b0, 8'hBB, 8'h00, 8'h00, 1'b0);

        stream();

        // Reset in the middle of a read, while in RWAIT.
        req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
        wait_ready("midrd");
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("midrd_in_rwait", {31'd0, mem_enable}, 32'd1);
        do_reset(2);
        check("midrd_ready", {31'd0, req_ready}, 32'd1);
        check("midrd_enable", {31'd0, mem_enable}, 32'd0);
        check("midrd_bus_oe", {31'd0, dut.bus_oe_q}, 32'd0);
        check("midrd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("midrd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        transact("post_wr", 1'b1, 8'h77, 8'hE1, 8'h00, 1'b0);
        transact("post_rd", 1'b0, 8'h77, 8'h00, 8'hE1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
